// File: rtl/cast_pkg.sv
// cast_pkg: shared types and clamp-limit helpers for the requantising cast path.
package cast_pkg;
   typedef enum logic [1:0] {ROUND_FLOOR = 2'd0, ROUND_HALF_UP = 2'd1, ROUND_HALF_EVEN = 2'd2} round_mode_e;
   function automatic longint clamp_max(input int ow);
      return (longint'(1) <<< (ow - 1)) - 1;
   endfunction
   function automatic longint clamp_min(input int ow, input bit sym);
      return -(longint'(1) <<< (ow - 1)) + (sym ? longint'(1) : longint'(0));
   endfunction
endpackage

// File: rtl/signed_round_clamp_stream_if.sv
// signed_round_clamp_stream_if: input and output beat streams of the requantiser.
interface signed_round_clamp_stream_if #(
   parameter int CHANNELS = 4,
   parameter int IN_WIDTH = 16,
   parameter int OUT_WIDTH = 8
);
   logic [CHANNELS-1:0][IN_WIDTH-1:0] data_in;
   logic data_in_valid;
   logic data_in_ready;
   logic [CHANNELS-1:0][OUT_WIDTH-1:0] data_out;
   logic data_out_valid;
   logic data_out_ready;
   logic [CHANNELS-1:0] sat_mask;
   modport master (output data_in, data_in_valid, data_out_ready, input data_in_ready, data_out, data_out_valid, sat_mask);
   modport slave (input data_in, data_in_valid, data_out_ready, output data_in_ready, data_out, data_out_valid, sat_mask);
endinterface

// File: rtl/signed_round_shift.sv
// signed_round_shift: one lane of biased arithmetic right shift; the result never overflows.
module signed_round_shift
   import cast_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int SHIFT = 4,
   parameter round_mode_e ROUND_MODE = ROUND_FLOOR
) (
   input  logic [IN_WIDTH-1:0] x,
   output logic [IN_WIDTH-SHIFT:0] y
);
   logic [IN_WIDTH:0] xe, bias, sum;
   assign xe = {x[IN_WIDTH-1], x};
   if (SHIFT == 0) begin : g_nobias
      assign bias = '0;
   end else begin : g_bias
      localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
      localparam logic [IN_WIDTH:0] HALF_M1 = HALF - (IN_WIDTH + 1)'(1);
      // half-even: a tie rounds up only when the kept lsb is odd
      assign bias = ROUND_MODE == ROUND_FLOOR ? '0 :
                    ROUND_MODE == ROUND_HALF_UP ? HALF :
                    HALF_M1 + {{IN_WIDTH{1'b0}}, xe[SHIFT]};
   end
   assign sum = xe + bias;
   assign y = (IN_WIDTH - SHIFT + 1)'(sum >> SHIFT);
endmodule

// File: rtl/signed_round_clamp_stream.sv
// signed_round_clamp_stream: two-stage round/shift then saturating clamp stream with saturation stats.
module signed_round_clamp_stream
   import cast_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT = 4,
   parameter int CHANNELS = 4,
   parameter bit SYMMETRIC = 1'b0,
   parameter round_mode_e ROUND_MODE = ROUND_FLOOR,
   parameter int CNT_WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   signed_round_clamp_stream_if.slave s,
   input  logic clear_stats,
   output logic [CNT_WIDTH-1:0] sat_count,
   output logic sat_sticky
);
   localparam int RW = IN_WIDTH - SHIFT + 1;
   localparam logic signed [RW-1:0] MAX_R = RW'(clamp_max(OUT_WIDTH));
   localparam logic signed [RW-1:0] MIN_R = RW'(clamp_min(OUT_WIDTH, SYMMETRIC));
   localparam logic [OUT_WIDTH-1:0] MAX_O = OUT_WIDTH'(clamp_max(OUT_WIDTH));
   localparam logic [OUT_WIDTH-1:0] MIN_O = OUT_WIDTH'(clamp_min(OUT_WIDTH, SYMMETRIC));
   logic s1_valid, s2_load, counted;
   logic [CHANNELS-1:0][RW-1:0] r_d, r_q;
   logic [CHANNELS-1:0][OUT_WIDTH-1:0] c;
   logic [CHANNELS-1:0] m;
   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      signed_round_shift #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .ROUND_MODE(ROUND_MODE)) u_rs (
         .x(s.data_in[i]),
         .y(r_d[i])
      );
   end
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         m[i] = $signed(r_q[i]) > MAX_R || $signed(r_q[i]) < MIN_R;
         c[i] = $signed(r_q[i]) > MAX_R ? MAX_O : $signed(r_q[i]) < MIN_R ? MIN_O : r_q[i][OUT_WIDTH-1:0];
      end
   end
   // each stage refills when empty or when its beat leaves this cycle
   assign s2_load = !s.data_out_valid || s.data_out_ready;
   assign s.data_in_ready = !s1_valid || s2_load;
   assign counted = s.data_out_valid && s.data_out_ready && |s.sat_mask;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid <= 1'b0;
         r_q <= '0;
      end else if (s.data_in_ready) begin
         s1_valid <= s.data_in_valid;
         if (s.data_in_valid) r_q <= r_d;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s.data_out_valid <= 1'b0;
         s.data_out <= '0;
         s.sat_mask <= '0;
      end else if (s2_load) begin
         s.data_out_valid <= s1_valid;
         if (s1_valid) begin
            s.data_out <= c;
            s.sat_mask <= m;
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sat_count <= '0;
         sat_sticky <= 1'b0;
      end else if (clear_stats) begin
         sat_count <= CNT_WIDTH'(counted);
         sat_sticky <= counted;
      end else if (counted) begin
         sat_count <= &sat_count ? sat_count : sat_count + CNT_WIDTH'(1);
         sat_sticky <= 1'b1;
      end
endmodule

// File: tb/tb_signed_round_clamp_stream.sv
// tb_signed_round_clamp_stream: four parameterisations driven by one stream, scoreboarded against an arithmetic model.
module tb_signed_round_clamp_stream;
   import cast_pkg::*;
   typedef struct {logic [63:0] data; logic [3:0] mask;} exp_t;
   localparam int CH[4] = '{4, 4, 4, 1};
   localparam int SH[4] = '{4, 4, 4, 0};
   localparam int OW[4] = '{8, 8, 8, 16};
   localparam int MD[4] = '{0, 1, 2, 0};
   localparam int SY[4] = '{0, 1, 0, 0};
   localparam longint CMX[2] = '{65535, 7};
   logic clk = 1'b0, rst = 1'b1, vin = 1'b0, ordy = 1'b1, clr = 1'b0;
   logic [3:0][15:0] din = '0;
   logic [15:0] cnt0, cnt2, cnt3;
   logic [2:0] cnt1;
   logic st0, st1, st2, st3;
   int nchk = 0, nerr = 0;
   exp_t sb[4][$];
   longint ec[2] = '{0, 0};
   bit es[2] = '{0, 0};
   bit stl[4] = '{0, 0, 0, 0};
   logic [63:0] hold[4];
   logic ov[4];
   logic [63:0] od[4];
   logic [3:0] om[4];
   always #5 clk = ~clk;
   signed_round_clamp_stream_if #(.CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(8)) if0 (), if1 (), if2 ();
   signed_round_clamp_stream_if #(.CHANNELS(1), .IN_WIDTH(16), .OUT_WIDTH(16)) if3 ();
   assign if0.data_in = din;
   assign if1.data_in = din;
   assign if2.data_in = din;
   assign if3.data_in = din[0];
   assign if0.data_in_valid = vin;
   assign if1.data_in_valid = vin;
   assign if2.data_in_valid = vin;
   assign if3.data_in_valid = vin;
   assign if0.data_out_ready = ordy;
   assign if1.data_out_ready = ordy;
   assign if2.data_out_ready = ordy;
   assign if3.data_out_ready = ordy;
   assign ov[0] = if0.data_out_valid;
   assign ov[1] = if1.data_out_valid;
   assign ov[2] = if2.data_out_valid;
   assign ov[3] = if3.data_out_valid;
   assign od[0] = 64'(if0.data_out);
   assign od[1] = 64'(if1.data_out);
   assign od[2] = 64'(if2.data_out);
   assign od[3] = 64'(if3.data_out);
   assign om[0] = if0.sat_mask;
   assign om[1] = if1.sat_mask;
   assign om[2] = if2.sat_mask;
   assign om[3] = 4'(if3.sat_mask);
   signed_round_clamp_stream #(.ROUND_MODE(ROUND_FLOOR)) u0 (
      .clk(clk), .rst(rst), .s(if0), .clear_stats(clr), .sat_count(cnt0), .sat_sticky(st0));
   signed_round_clamp_stream #(.SYMMETRIC(1'b1), .ROUND_MODE(ROUND_HALF_UP), .CNT_WIDTH(3)) u1 (
      .clk(clk), .rst(rst), .s(if1), .clear_stats(clr), .sat_count(cnt1), .sat_sticky(st1));
   signed_round_clamp_stream #(.ROUND_MODE(ROUND_HALF_EVEN)) u2 (
      .clk(clk), .rst(rst), .s(if2), .clear_stats(clr), .sat_count(cnt2), .sat_sticky(st2));
   signed_round_clamp_stream #(.OUT_WIDTH(16), .SHIFT(0), .CHANNELS(1)) u3 (
      .clk(clk), .rst(rst), .s(if3), .clear_stats(clr), .sat_count(cnt3), .sat_sticky(st3));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // exact rational rounding: floor quotient plus remainder-based correction
   function automatic exp_t model(input logic [3:0][15:0] d, input int k);
      exp_t e;
      e.data = '0;
      e.mask = '0;
      for (int i = 0; i < CH[k]; i++) begin
         longint v, sc, q, r, mx, mn;
         v = longint'($signed(d[i]));
         sc = longint'(1) <<< SH[k];
         q = v >>> SH[k];
         r = v - q * sc;
         mx = (longint'(1) <<< (OW[k] - 1)) - 1;
         mn = -mx - 1 + longint'(SY[k]);
         if (MD[k] == 1 && 2 * r >= sc && SH[k] > 0) q++;
         if (MD[k] == 2 && SH[k] > 0 && (2 * r > sc || (2 * r == sc && q[0]))) q++;
         e.mask[i] = q > mx || q < mn;
         q = q > mx ? mx : q < mn ? mn : q;
         e.data |= 64'(q & ((longint'(1) <<< OW[k]) - 1)) << (i * OW[k]);
      end
      return e;
   endfunction

   always @(negedge clk) if (!rst) begin
      exp_t e;
      chk("cnt0", 64'(cnt0), 64'(ec[0]));
      chk("stk0", 64'(st0), 64'(es[0]));
      chk("cnt1", 64'(cnt1), 64'(ec[1]));
      chk("stk1", 64'(st1), 64'(es[1]));
      for (int k = 0; k < 4; k++) begin
         if (stl[k]) chk($sformatf("hold%0d", k), od[k], hold[k]);
         stl[k] = ov[k] && !ordy;
         hold[k] = od[k];
         if (ov[k] && ordy) begin
            if (sb[k].size() == 0) chk($sformatf("spurious%0d", k), 64'(1), 64'(0));
            else begin
               e = sb[k].pop_front();
               chk($sformatf("data%0d", k), od[k], e.data);
               chk($sformatf("mask%0d", k), 64'(om[k]), 64'(e.mask));
            end
         end
         if (vin && if0.data_in_ready) sb[k].push_back(model(din, k));
      end
      for (int k = 0; k < 2; k++) begin
         bit xf;
         xf = ov[k] && ordy && |om[k];
         if (clr) begin
            ec[k] = longint'(xf);
            es[k] = xf;
         end else if (xf) begin
            if (ec[k] != CMX[k]) ec[k]++;
            es[k] = 1'b1;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0][15:0] d);
      din = d;
      vin = 1'b1;
      idle(1);
      vin = 1'b0;
   endtask

   task automatic one_beat(input logic [3:0][15:0] d, input string tag);
      int n;
      n = 0;
      din = d;
      vin = 1'b1;
      ordy = 1'b1;
      while (n < 10) begin
         @(posedge clk);
         #1;
         vin = 1'b0;
         n++;
         if (if0.data_out_valid) break;
      end
      chk(tag, 64'(n), 64'(2));
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0; n++) idle(1);
      for (int k = 0; k < 4; k++) chk($sformatf("drain%0d", k), 64'(sb[k].size()), 64'(0));
   endtask

   initial begin
      int sent;
      idle(2);
      chk("rst_valid", {ov[0], ov[1], ov[2], ov[3]}, 64'(0));
      chk("rst_data", od[0] | od[3], 64'(0));
      chk("rst_mask", 64'(om[0] | om[1]), 64'(0));
      chk("rst_rdy", 64'(if0.data_in_ready), 64'(1));
      chk("rst_stats", {cnt0, 3'(cnt1), st0, st1}, 64'(0));
      rst = 1'b0;
      idle(1);
      one_beat({16'hFFD8, 16'hFFE8, 16'h0028, 16'h0018}, "lat_first");
      send({16'h07F0, 16'h07F8, 16'h8000, 16'h7FFF});
      send({16'h07F8, 16'h07F0, 16'h7FFF, 16'h8000});
      send({16'h0008, 16'hFFF8, 16'h0018, 16'hFFD8});
      drain();
      sent = 0;
      for (int c = 0; sent < 10 && c < 200; c++) begin
         for (int k = 0; k < 4; k++) din[k] = 16'(sent * 173 - 700 + k * 59);
         vin = 1'b1;
         ordy = c < 3 ? 1'b1 : c <= 7 ? 1'b0 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (c >= 3 && c <= 7) chk($sformatf("bp_rdy_c%0d", c), 64'(if0.data_in_ready), 64'(0));
         if (if0.data_in_ready) sent++;
         idle(1);
      end
      chk("bp_sent", 64'(sent), 64'(10));
      vin = 1'b0;
      ordy = 1'b1;
      drain();
      for (int i = 0; i < 9; i++) send({4{16'h7FFF}});
      idle(4);
      chk("sat_cnt_wrap", 64'(cnt1), 64'(7));
      chk("sat_stk", 64'(st1), 64'(1));
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      chk("clr_alone", {cnt0, 3'(cnt1), st0, st1}, 64'(0));
      send({4{16'h8000}});
      idle(1);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      chk("clr_xfer1", {61'(cnt1), st1}, {61'(1), 1'b1});
      chk("clr_xfer0", {61'(cnt0), st0}, {61'(1), 1'b1});
      drain();
      ordy = 1'b0;
      send({4{16'h7FFF}});
      send({4{16'h1234}});
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", {ov[0], ov[1], ov[2], ov[3]}, 64'(0));
      chk("arst_stats", {cnt0, 3'(cnt1), st0, st1}, 64'(0));
      for (int k = 0; k < 4; k++) begin
         sb[k].delete();
         stl[k] = 1'b0;
      end
      ec = '{0, 0};
      es = '{0, 0};
      @(posedge clk);
      #1 rst = 1'b0;
      ordy = 1'b1;
      idle(1);
      one_beat({16'h0100, 16'hFF00, 16'h0031, 16'hFFCF}, "lat_post_rst");
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/signed_round_clamp_stream.md
# signed_round_clamp_stream

Multi-channel streaming requantiser: takes a vector of signed fixed-point lanes, right-shifts each lane by a fixed number of fractional bits using a selectable rounding mode, then saturates each lane to a narrower signed width (optionally symmetric). It sits between accumulator/MAC outputs and the next layer's input in the cast path. It carries a valid/ready stream with a two-stage register pipeline and full throughput, and it keeps per-beat saturation flags and running saturation statistics.

## Interface
- IN_WIDTH, 16, input lane width (signed)
- OUT_WIDTH, 8, output lane width (signed); must satisfy OUT_WIDTH <= IN_WIDTH - SHIFT + 1
- SHIFT, 4, fractional bits removed (arithmetic right shift); 0 allowed
- CHANNELS, 4, lanes per beat
- SYMMETRIC, 0, 1 → MIN = -(2^(OUT_WIDTH-1))+1; 0 → MIN = -(2^(OUT_WIDTH-1))
- ROUND_MODE, 0, 0 floor (truncate toward -inf), 1 round-half-up, 2 round-half-even
- CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_in  in  [CHANNELS][IN_WIDTH]  signed input lanes
- data_in_valid  in  1  input beat valid
- data_in_ready  out  1  block accepts beat
- data_out  out  [CHANNELS][OUT_WIDTH]  requantised lanes
- data_out_valid  out  1  output beat valid
- data_out_ready  in  1  downstream accepts beat
- sat_mask  out  [CHANNELS]  per-lane clamp flag, aligned with data_out
- sat_count  out  CNT_WIDTH  beats delivered with ≥1 saturated lane
- sat_sticky  out  1  set on any delivered saturated beat
- clear_stats  in  1  synchronous clear of sat_count/sat_sticky

## Operation
- Stage 1 (round/shift), per lane: sign-extend to IN_WIDTH+1. Bias: mode 0 → 0; mode 1 → 2^(SHIFT-1); mode 2 → 2^(SHIFT-1)-1 + bit SHIFT of input. Add bias, then arithmetic shift right by SHIFT. Result width IN_WIDTH-SHIFT+1; no overflow is possible. SHIFT=0 → bias 0 in all modes.
- Stage 2 (clamp), per lane: if r > MAX (2^(OUT_WIDTH-1)-1) → MAX with sat bit 1. If r < MIN → MIN with sat bit 1. Otherwise r truncated to OUT_WIDTH with sat bit 0. A rounding carry into overflow (e.g. 127.5 → 128) counts as saturation.
- Handshake: each stage register loads when it is empty or its contents are leaving that cycle.
  - data_in_ready = !s1_valid || s2_load.
  - s2_load = !s2_valid || data_out_ready.
  - Transfer occurs on valid && ready. Stage data holds while stalled.
- data_out_valid must not depend combinationally on data_out_ready. data_in_ready may depend combinationally on data_out_ready.
- Stats update on each output transfer whose sat_mask ≠ 0:
  - sat_count += 1, saturating at all-ones (no wrap).
  - sat_sticky ← 1.
- clear_stats together with a counted transfer: sat_count ← 1 and sat_sticky ← 1. clear_stats alone: both ← 0.

## Timing
- Latency 2 cycles input transfer → data_out_valid, with no stall. Throughput 1 beat/cycle.
- Under stall, at most 2 beats are buffered. data_in_ready falls the cycle both stages hold data with data_out_ready low.
- Reset (async assert, sync release), all values 0: data_out, sat_mask, data_out_valid, internal valids, sat_count, sat_sticky. data_in_ready = 1 after reset.
- Reset mid-stream discards in-flight beats; no partial beat emerges.
- Stats are visible the cycle after the counted transfer.

## Structure
- Shared package cast_pkg holds:
  - typedef enum round_mode_e {ROUND_FLOOR=0, ROUND_HALF_UP=1, ROUND_HALF_EVEN=2}
  - functions computing clamp MIN/MAX from OUT_WIDTH/SYMMETRIC
- Sub-module signed_round_shift: combinational per-lane bias+shift, instantiated CHANNELS times in stage 1.
- Clamp logic and the pipeline/handshake live in the top.

## Test plan
Default parameters (IN 16, OUT 8, SHIFT 4) unless noted.
- Rounding: lane inputs 0x0018 (1.5), 0x0028 (2.5), 0xFFE8 (-1.5), 0xFFD8 (-2.5):
  - mode 0 → 1, 2, -2, -3
  - mode 1 → 2, 3, -1, -2
  - mode 2 → 2, 2, -2, -2
  - sat_mask 0 in all modes
- Clamp: 0x7FFF → 127, sat 1. 0x8000 → -128 (SYMMETRIC=0) or -127 (SYMMETRIC=1), sat 1. 0x07F8 mode 1 → 127, sat 1. 0x07F0 → 127, sat 0.
- Backpressure:
  - Stimulus: 10-beat ramp with valid held high; data_out_ready low for cycles 3–7, then random.
  - Required: data_in_ready low after 2 beats buffered; output sequence exact, no loss or duplication; data_out stable while stalled.
- Stats:
  - CNT_WIDTH=3, 9 saturating beats → sat_count=7, sat_sticky=1.
  - clear_stats alone → 0/0.
  - clear_stats with a saturating transfer → 1/1.
- SHIFT=0, CHANNELS=1, OUT_WIDTH=IN_WIDTH: output equals input for 0x8000 and 0x7FFF, sat 0 when SYMMETRIC=0.
- Reset asserted mid-stream with 2 beats in flight:
  - data_out_valid and stats go to 0 immediately (asynchronously).
  - Stale beats are never emitted after release.
  - The first post-reset beat appears 2 cycles after acceptance.
